// File: rtl/aes_cipher_pipe.sv
// Elastic, fully unrolled AES encryption pipeline: one stage per round, per-stage
// valid/ready with a combinational ready chain, tag sideband and occupancy count.

module aes_cipher_pipe #(
    parameter int Nk    = 4,
    parameter int Nr    = Nk + 6,
    parameter int TAG_W = 8,
    parameter int OCC_W = $clog2(Nr + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [127:0]     k_sch [0:Nr],
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     pt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     ct,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [OCC_W-1:0] occupancy
);

    localparam int unsigned      NS      = Nr + 1;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(NS);

    generate
        if (!(Nk == 4 || Nk == 6 || Nk == 8) || (Nr != Nk + 6) || (TAG_W < 1)) begin : g_bad_cfg
            $error("aes_cipher_pipe: Nk must be 4, 6 or 8 with Nr = Nk + 6 and TAG_W >= 1");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box built from the field inverse x^254 = x^2*x^4*...*x^128 (0 maps to 0)
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Byte k sits at bits [127-8k -: 8]; state is column-major, byte k = row k%4, column k/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned rw = 0; rw < 4; rw++) begin
                r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c + rw) % 4) + rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    logic [127:0]     d_q   [0:Nr];
    logic [TAG_W-1:0] t_q   [0:Nr];
    logic [Nr:0]      v_q;
    logic [127:0]     d_d   [0:Nr];
    logic [TAG_W-1:0] t_src [0:Nr];
    logic [Nr:0]      v_src;
    logic [Nr:0]      rdy;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_fire;
    logic             out_fire;

    assign v_src    = {v_q[Nr-1:0], in_valid};
    assign d_d[0]   = pt ^ k_sch[0];
    assign t_src[0] = in_tag;

    for (genvar g = 1; g <= Nr; g++) begin : g_round
        logic [127:0] sr;
        assign sr       = shift_rows(sub_bytes(d_q[g-1]));
        assign t_src[g] = t_q[g-1];
        if (g == Nr) begin : g_last
            assign d_d[g] = sr ^ k_sch[g];
        end else begin : g_mid
            assign d_d[g] = mix_columns(sr) ^ k_sch[g];
        end
    end

    // r[i] = !v[i] | r[i+1] unrolled: stage g is blocked only when it and every
    // stage after it are full while the consumer stalls.
    for (genvar g = 0; g <= Nr; g++) begin : g_ready
        assign rdy[g] = out_ready | ~(&v_q[Nr:g]);
    end

    assign in_ready = rdy[0];
    assign in_fire  = in_valid & rdy[0];
    assign out_fire = v_q[Nr] & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (in_fire && !out_fire && (occ_q != OCC_MAX)) begin
            occ_d = occ_q + 1'b1;
        end else if (out_fire && !in_fire && (occ_q != '0)) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int unsigned i = 0; i < NS; i++) begin
                d_q[i] <= '0;
                t_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int unsigned i = 0; i < NS; i++) begin
                if (rdy[i]) begin
                    v_q[i] <= v_src[i];
                    if (v_src[i]) begin
                        d_q[i] <= d_d[i];
                        t_q[i] <= t_src[i];
                    end
                end
            end
        end
    end

    assign ct        = d_q[Nr];
    assign out_tag   = t_q[Nr];
    assign out_valid = v_q[Nr];
    assign busy      = |v_q;
    assign occupancy = occ_q;

endmodule
